hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/control_pkg.sv | 31 +++
 rtl/hazard_scoreboard_if.sv | 53 +++++
 rtl/hazard_src_decode.sv | 30 +++
 rtl/hazard_scoreboard.sv | 130 +++++++++++++
 tb/tb_hazard_scoreboard.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/control_pkg.sv
// Shared types for the hazard scoreboard: instruction classes, operating modes
// and the saturating-increment helper used by the optional perf counters.
package control_pkg;

  typedef enum logic [3:0] {
    IT_R      = 4'd0,
    IT_I      = 4'd1,
    IT_LOAD   = 4'd2,
    IT_STORE  = 4'd3,
    IT_BRANCH = 4'd4,
    IT_JAL    = 4'd5,
    IT_JALR   = 4'd6,
    IT_LUI    = 4'd7,
    IT_AUIPC  = 4'd8,
    IT_SYSTEM = 4'd9,
    IT_FENCE  = 4'd10,
    IT_NOP    = 4'd11
  } instruction_type_e;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LOAD_USE = 2'd1,
    REDIRECT = 2'd2,
    MEM_WAIT = 2'd3
  } op_mode_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode/execute/pipeline-control bundle between the pipeline (master) and the
// hazard scoreboard (slave). Perf counter signals exist only with HAZARD_PERF_EN.
interface hazard_scoreboard_if
  import control_pkg::*;
#(
  parameter int NUM_REGS = 32
);
  localparam int REG_W = $clog2(NUM_REGS);

  logic              id_valid;
  logic [REG_W-1:0]  id_rs1;
  logic [REG_W-1:0]  id_rs2;
  logic [REG_W-1:0]  id_rd;
  instruction_type_e id_instruction_type;
  logic              ex_valid;
  instruction_type_e ex_instruction_type;
  logic              ex_taken;
  logic              mem_ready;
  logic              stall_pc;
  logic              stall_ifid;
  logic              stall_idex;
  logic              flush_ifid;
  logic              flush_idex;
  logic [NUM_REGS-1:0] busy_mask;
`ifdef HAZARD_PERF_EN
  logic [31:0]       stall_cycles;
  logic [31:0]       redirect_count;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_instruction_type,
    output ex_valid, ex_instruction_type, ex_taken, mem_ready,
    input  stall_pc, stall_ifid, stall_idex, flush_ifid, flush_idex, busy_mask,
    input  stall_cycles, redirect_count
  );
  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_instruction_type,
    input  ex_valid, ex_instruction_type, ex_taken, mem_ready,
    output stall_pc, stall_ifid, stall_idex, flush_ifid, flush_idex, busy_mask,
    output stall_cycles, redirect_count
  );
`else
  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_instruction_type,
    output ex_valid, ex_instruction_type, ex_taken, mem_ready,
    input  stall_pc, stall_ifid, stall_idex, flush_ifid, flush_idex, busy_mask
  );
  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_instruction_type,
    input  ex_valid, ex_instruction_type, ex_taken, mem_ready,
    output stall_pc, stall_ifid, stall_idex, flush_ifid, flush_idex, busy_mask
  );
`endif
endinterface

// File: rtl/hazard_src_decode.sv
// Maps an instruction class to which source registers it actually reads.
module hazard_src_decode
  import control_pkg::*;
(
  input  instruction_type_e i_type,
  output logic              o_use_rs1,
  output logic              o_use_rs2
);

  // Source-register usage per instruction class
  always_comb begin
    o_use_rs1 = 1'b0;
    o_use_rs2 = 1'b0;
    case (i_type)
      IT_R, IT_STORE, IT_BRANCH: begin
        o_use_rs1 = 1'b1;
        o_use_rs2 = 1'b1;
      end
      IT_I, IT_LOAD, IT_JALR: begin
        o_use_rs1 = 1'b1;
        o_use_rs2 = 1'b0;
      end
      default: begin
        o_use_rs1 = 1'b0;
        o_use_rs2 = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Load-use / redirect / memory-wait hazard unit with a per-register countdown
// scoreboard. Optional perf counters are enabled by the macro HAZARD_PERF_EN.
module hazard_scoreboard
  import control_pkg::*;
#(
  parameter int LOAD_LATENCY = 2,
  parameter int NUM_REGS     = 32
) (
  input  logic clk,
  input  logic rst_n,
  hazard_scoreboard_if.slave bus
);
  localparam int CNT_W = $clog2(LOAD_LATENCY + 1);
  localparam int REG_W = $clog2(NUM_REGS);

  logic [CNT_W-1:0] r_cnt [NUM_REGS];
  logic             w_use_rs1;
  logic             w_use_rs2;
  logic             w_load_use;
  logic             w_redirect;
  logic             w_issue;
  op_mode_e         w_mode;

  hazard_src_decode u_src_decode (
    .i_type    (bus.id_instruction_type),
    .o_use_rs1 (w_use_rs1),
    .o_use_rs2 (w_use_rs2)
  );

  // Hazard detection, mode priority and pipeline control outputs
  always_comb begin
    w_load_use = bus.id_valid &&
                 ((w_use_rs1 && (bus.id_rs1 != {REG_W{1'b0}}) && (r_cnt[bus.id_rs1] != {CNT_W{1'b0}})) ||
                  (w_use_rs2 && (bus.id_rs2 != {REG_W{1'b0}}) && (r_cnt[bus.id_rs2] != {CNT_W{1'b0}})));
    w_redirect = bus.ex_valid &&
                 (((bus.ex_instruction_type == IT_BRANCH) && bus.ex_taken) ||
                  (bus.ex_instruction_type == IT_JAL) || (bus.ex_instruction_type == IT_JALR));
    if (!bus.mem_ready) begin
      w_mode = MEM_WAIT;
    end else if (w_redirect) begin
      w_mode = REDIRECT;
    end else if (w_load_use) begin
      w_mode = LOAD_USE;
    end else begin
      w_mode = RUN;
    end
    bus.stall_pc   = 1'b0;
    bus.stall_ifid = 1'b0;
    bus.stall_idex = 1'b0;
    bus.flush_ifid = 1'b0;
    bus.flush_idex = 1'b0;
    case (w_mode)
      MEM_WAIT: begin
        bus.stall_pc   = 1'b1;
        bus.stall_ifid = 1'b1;
        bus.stall_idex = 1'b1;
      end
      REDIRECT: begin
        bus.flush_ifid = 1'b1;
        bus.flush_idex = 1'b1;
      end
      LOAD_USE: begin
        bus.stall_pc   = 1'b1;
        bus.stall_ifid = 1'b1;
        bus.flush_idex = 1'b1;
      end
      default: begin
        bus.stall_pc   = 1'b0;
      end
    endcase
    w_issue = bus.id_valid && (bus.id_instruction_type == IT_LOAD) &&
              !bus.stall_ifid && !bus.flush_idex;
  end

  // Busy view of the scoreboard
  always_comb begin
    bus.busy_mask = {NUM_REGS{1'b0}};
    for (int r = 0; r < NUM_REGS; r++) begin
      bus.busy_mask[r] = (r_cnt[r] != {CNT_W{1'b0}});
    end
  end

  // Countdown scoreboard; a same-cycle issue wins over the decrement
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        r_cnt[r] <= {CNT_W{1'b0}};
      end
    end else begin
      r_cnt[0] <= {CNT_W{1'b0}};
      for (int r = 1; r < NUM_REGS; r++) begin
        if (w_issue && (bus.id_rd == REG_W'(r))) begin
          r_cnt[r] <= CNT_W'(LOAD_LATENCY);
        end else if (bus.mem_ready && (r_cnt[r] != {CNT_W{1'b0}})) begin
          r_cnt[r] <= r_cnt[r] - CNT_W'(1);
        end else begin
          r_cnt[r] <= r_cnt[r];
        end
      end
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_redirect_count;

  // Saturating stall / redirect cycle counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles   <= 32'd0;
      r_redirect_count <= 32'd0;
    end else begin
      if ((w_mode == MEM_WAIT) || (w_mode == LOAD_USE)) begin
        r_stall_cycles <= sat_inc(r_stall_cycles);
      end else begin
        r_stall_cycles <= r_stall_cycles;
      end
      if (w_mode == REDIRECT) begin
        r_redirect_count <= sat_inc(r_redirect_count);
      end else begin
        r_redirect_count <= r_redirect_count;
      end
    end
  end

  assign bus.stall_cycles   = r_stall_cycles;
  assign bus.redirect_count = r_redirect_count;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench: directed vector table, reset corner cases and a random
// run against a pending-load queue model.
module tb_hazard_scoreboard;
  import control_pkg::*;

  localparam int LL = 2;
  localparam logic [4:0] C_RUN = 5'b00000;
  localparam logic [4:0] C_LU  = 5'b11001;
  localparam logic [4:0] C_MW  = 5'b11100;
  localparam logic [4:0] C_RD  = 5'b00011;
  localparam logic [31:0] B3 = 32'h0000_0008;
  localparam logic [31:0] B5 = 32'h0000_0020;
  localparam logic [31:0] B7 = 32'h0000_0080;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.NUM_REGS(32)) hz ();

  hazard_scoreboard #(.LOAD_LATENCY(LL), .NUM_REGS(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (hz.slave)
  );

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic id_valid; instruction_type_e id_type;
    logic [4:0] rs1; logic [4:0] rs2; logic [4:0] rd;
    logic ex_valid; instruction_type_e ex_type; logic ex_taken; logic mem_ready;
    logic [4:0] exp_ctl; logic [31:0] exp_busy;
  } vec_t;
  vec_t tbl[24];

  typedef struct { int rd; int left; } pend_t;
  pend_t pq[$];
  logic [4:0]  m_ctl;
  logic [31:0] m_busy;
  bit          m_issue;
  longint      m_stall = 0;
  longint      m_redir = 0;

  function automatic vec_t mk(bit iv, instruction_type_e it, int s1, int s2, int d,
                              bit ev, instruction_type_e et, bit tk, bit mr,
                              logic [4:0] c, logic [31:0] b);
    vec_t v;
    v.id_valid = iv; v.id_type = it; v.rs1 = 5'(s1); v.rs2 = 5'(s2); v.rd = 5'(d);
    v.ex_valid = ev; v.ex_type = et; v.ex_taken = tk; v.mem_ready = mr;
    v.exp_ctl = c; v.exp_busy = b;
    return v;
  endfunction

  function automatic bit reg_busy(logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    foreach (pq[i]) if (pq[i].rd == int'(r)) return 1'b1;
    return 1'b0;
  endfunction

  // Reference: a register is busy while any load to it is still in flight
  function automatic void model_eval();
    bit lu, rdr, u1, u2;
    u1 = hz.id_instruction_type inside {IT_R, IT_STORE, IT_BRANCH, IT_I, IT_LOAD, IT_JALR};
    u2 = hz.id_instruction_type inside {IT_R, IT_STORE, IT_BRANCH};
    lu = hz.id_valid && ((u1 && reg_busy(hz.id_rs1)) || (u2 && reg_busy(hz.id_rs2)));
    rdr = hz.ex_valid && ((hz.ex_instruction_type == IT_BRANCH && hz.ex_taken) ||
                          hz.ex_instruction_type inside {IT_JAL, IT_JALR});
    if (!hz.mem_ready) m_ctl = C_MW;
    else if (rdr)      m_ctl = C_RD;
    else if (lu)       m_ctl = C_LU;
    else               m_ctl = C_RUN;
    m_issue = hz.id_valid && (hz.id_instruction_type == IT_LOAD) && !m_ctl[3] && !m_ctl[0];
    for (int r = 0; r < 32; r++) m_busy[r] = reg_busy(5'(r));
  endfunction

  function automatic void model_edge();
    if (hz.mem_ready) begin
      for (int i = pq.size() - 1; i >= 0; i--) begin
        pq[i].left = pq[i].left - 1;
        if (pq[i].left == 0) pq.delete(i);
      end
    end
    if (m_issue && hz.id_rd != 5'd0) pq.push_back('{int'(hz.id_rd), LL});
    if (m_ctl == C_MW || m_ctl == C_LU) m_stall++;
    if (m_ctl == C_RD) m_redir++;
  endfunction

  task automatic check(string name, logic [36:0] act, logic [36:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [36:0] dut_out();
    return {hz.stall_pc, hz.stall_ifid, hz.stall_idex, hz.flush_ifid, hz.flush_idex, hz.busy_mask};
  endfunction

  task automatic set_in(bit iv, instruction_type_e it, logic [4:0] s1, logic [4:0] s2, logic [4:0] d,
                        bit ev, instruction_type_e et, bit tk, bit mr);
    hz.id_valid = iv; hz.id_instruction_type = it; hz.id_rs1 = s1; hz.id_rs2 = s2; hz.id_rd = d;
    hz.ex_valid = ev; hz.ex_instruction_type = et; hz.ex_taken = tk; hz.mem_ready = mr;
  endtask

  // One cycle: compare mid-cycle, then advance model across the edge
  task automatic cyc(bit use_const, logic [4:0] ectl, logic [31:0] ebusy, string name);
    #3;
    model_eval();
    if (use_const) check(name, dut_out(), {ectl, ebusy});
    else           check(name, dut_out(), {m_ctl, m_busy});
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    tbl[0]  = mk(1, IT_LOAD,   0, 0, 5,  0, IT_NOP,    0, 1, C_RUN, 32'd0);
    tbl[1]  = mk(1, IT_R,      5, 1, 6,  0, IT_NOP,    0, 1, C_LU,  B5);
    tbl[2]  = mk(1, IT_R,      5, 1, 6,  0, IT_NOP,    0, 1, C_LU,  B5);
    tbl[3]  = mk(1, IT_R,      5, 1, 6,  0, IT_NOP,    0, 1, C_RUN, 32'd0);
    tbl[4]  = mk(1, IT_LOAD,   0, 0, 5,  0, IT_NOP,    0, 1, C_RUN, 32'd0);
    tbl[5]  = mk(1, IT_R,      5, 1, 6,  0, IT_NOP,    0, 1, C_LU,  B5);
    tbl[6]  = mk(1, IT_R,      5, 1, 6,  0, IT_NOP,    0, 0, C_MW,  B5);
    tbl[7]  = mk(1, IT_R,      5, 1, 6,  0, IT_NOP,    0, 0, C_MW,  B5);
    tbl[8]  = mk(1, IT_R,      5, 1, 6,  0, IT_NOP,    0, 0, C_MW,  B5);
    tbl[9]  = mk(1, IT_R,      5, 1, 6,  0, IT_NOP,    0, 1, C_LU,  B5);
    tbl[10] = mk(1, IT_R,      5, 1, 6,  0, IT_NOP,    0, 1, C_RUN, 32'd0);
    tbl[11] = mk(1, IT_LOAD,   0, 0, 7,  0, IT_NOP,    0, 1, C_RUN, 32'd0);
    tbl[12] = mk(1, IT_R,      7, 1, 8,  1, IT_BRANCH, 1, 1, C_RD,  B7);
    tbl[13] = mk(1, IT_LOAD,   0, 0, 9,  1, IT_JAL,    0, 0, C_MW,  B7);
    tbl[14] = mk(1, IT_LOAD,   0, 0, 9,  1, IT_JAL,    0, 1, C_RD,  B7);
    tbl[15] = mk(1, IT_R,      9, 7, 10, 0, IT_NOP,    0, 1, C_RUN, 32'd0);
    tbl[16] = mk(1, IT_LOAD,   0, 0, 0,  0, IT_NOP,    0, 1, C_RUN, 32'd0);
    tbl[17] = mk(1, IT_R,      0, 0, 11, 0, IT_NOP,    0, 1, C_RUN, 32'd0);
    tbl[18] = mk(1, IT_LOAD,   0, 0, 3,  0, IT_NOP,    0, 1, C_RUN, 32'd0);
    tbl[19] = mk(1, IT_I,      4, 3, 12, 0, IT_NOP,    0, 1, C_RUN, B3);
    tbl[20] = mk(1, IT_STORE,  4, 3, 0,  0, IT_NOP,    0, 1, C_LU,  B3);
    tbl[21] = mk(1, IT_STORE,  4, 3, 0,  0, IT_NOP,    0, 1, C_RUN, 32'd0);
    tbl[22] = mk(0, IT_NOP,    0, 0, 0,  1, IT_BRANCH, 0, 1, C_RUN, 32'd0);
    tbl[23] = mk(0, IT_NOP,    0, 0, 0,  0, IT_JAL,    0, 1, C_RUN, 32'd0);

    // Reset with idle inputs
    set_in(0, IT_NOP, 5'd0, 5'd0, 5'd0, 0, IT_NOP, 0, 0);
    #12;
    check("reset_idle", dut_out(), {C_MW, 32'd0});
    hz.mem_ready = 1'b1;
    #1;
    check("reset_outputs", dut_out(), {C_RUN, 32'd0});
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 24; i++) begin
      set_in(tbl[i].id_valid, tbl[i].id_type, tbl[i].rs1, tbl[i].rs2, tbl[i].rd,
             tbl[i].ex_valid, tbl[i].ex_type, tbl[i].ex_taken, tbl[i].mem_ready);
      cyc(1'b1, tbl[i].exp_ctl, tbl[i].exp_busy, $sformatf("vec%0d", i));
    end

    // Asynchronous reset in the middle of a load-use stall
    set_in(1, IT_LOAD, 5'd0, 5'd0, 5'd7, 0, IT_NOP, 0, 1);
    cyc(1'b1, C_RUN, 32'd0, "mid_load7");
    set_in(1, IT_R, 5'd7, 5'd1, 5'd2, 0, IT_NOP, 0, 1);
    #3;
    check("mid_stall", dut_out(), {C_LU, B7});
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_clear", dut_out(), {C_RUN, 32'd0});
`ifdef HAZARD_PERF_EN
    check("async_reset_perf", {5'd0, hz.stall_cycles}, 37'd0);
`endif
    pq.delete();
    m_stall = 0;
    m_redir = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc(1'b1, C_RUN, 32'd0, "post_reset_run");

    // Random traffic against the queue model
    for (int n = 0; n < 400; n++) begin
      logic [3:0] t_id, t_ex;
      t_id = ($urandom_range(0, 9) < 3) ? 4'(IT_LOAD) : 4'($urandom_range(0, 11));
      t_ex = 4'($urandom_range(0, 11));
      set_in(1'($urandom_range(0, 1) | $urandom_range(0, 1)), instruction_type_e'(t_id),
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)), instruction_type_e'(t_ex), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 4) != 0));
      cyc(1'b0, 5'd0, 32'd0, $sformatf("rand%0d", n));
    end

`ifdef HAZARD_PERF_EN
    check("perf_stall_cycles", {5'd0, hz.stall_cycles}, {5'd0, 32'(m_stall)});
    check("perf_redirect_count", {5'd0, hz.redirect_count}, {5'd0, 32'(m_redir)});
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
